// File: rtl/instr_frame_assembler_pkg.sv
// Shared CPU front-end types: opcodes, legality/immediate decode, abort codes,
// FSM state encoding and accumulator control bundle.
package cpu_pkg;

  localparam int OPC_BITS = 3;

  typedef enum logic [OPC_BITS-1:0] {
    R_TYPE  = 3'd0,
    I_TYPE  = 3'd1,
    B_TYPE  = 3'd2,
    J_TYPE  = 3'd3,
    M_TYPE  = 3'd4,
    SYS_END = 3'd7
  } opcode_t;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL_OPC = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT     = 2'b10;

  typedef enum logic [1:0] {
    S_INSTR = 2'd0,
    S_IMM   = 2'd1,
    S_HOLD  = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic clr;
    logic instr_shift;
    logic imm_shift;
  } accum_ctrl_t;

  function automatic logic is_legal_opc(input logic [OPC_BITS-1:0] opc);
    case (opcode_t'(opc))
      R_TYPE, I_TYPE, B_TYPE, J_TYPE, M_TYPE, SYS_END: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic has_imm(input logic [OPC_BITS-1:0] opc);
    return (opcode_t'(opc) == I_TYPE) || (opcode_t'(opc) == M_TYPE);
  endfunction

endpackage

// File: rtl/instr_frame_assembler_if.sv
// Serial-in / frame-out bus of the instruction frame assembler.
// master = the assembler itself, slave = fetch/decode environment.
interface instr_frame_assembler_if #(
  parameter int BYTE_W  = 8,
  parameter int INSTR_W = 16,
  parameter int IMM_W   = 16
);
  logic               in_valid;
  logic [BYTE_W-1:0]  in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [IMM_W-1:0]   out_imm;
  logic               out_has_imm;
  logic               error;
  logic [1:0]         err_code;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_has_imm, error, err_code
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_has_imm, error, err_code
  );
endinterface

// File: rtl/instr_frame_assembler_byte_word_accum.sv
// Little-endian byte-to-word accumulator: beat n lands in slice n.
// last_beat flags (combinationally) that the beat being shifted completes the word.
module byte_word_accum #(
  parameter  int BYTE_W = 8,
  parameter  int WORD_W = 16,
  localparam int NB     = WORD_W / BYTE_W,
  localparam int CNT_W  = $clog2(NB + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic [CNT_W-1:0]  count,
  output logic              last_beat
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_out <= '0;
      count    <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < NB; i++)
        if (count == CNT_W'(i)) word_out[i*BYTE_W +: BYTE_W] <= byte_in;
      // saturate so a stray beat after completion cannot wrap into slice 0
      if (count != CNT_W'(NB)) count <= count + 1'b1;
    end
  end

  assign last_beat = shift_en && (count == CNT_W'(NB - 1));

endmodule

// File: rtl/instr_frame_assembler.sv
// Assembles opcode-length instruction frames (+ optional immediate) from a byte stream.
// Optional inter-byte timeout abort: define INSTR_FRAME_TIMEOUT_EN.
module instr_frame_assembler
  import cpu_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int IMM_W       = 16,
  parameter int OPC_W       = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input logic clk,
  input logic rst,
  instr_frame_assembler_if.master bus
);

  localparam int IB   = INSTR_W / BYTE_W;
  localparam int MB   = IMM_W / BYTE_W;
  localparam int IC_W = $clog2(IB + 1);
  localparam int MC_W = $clog2(MB + 1);

  fsm_state_t   state;
  logic         in_ready_q, out_valid_q, has_imm_q, error_q;
  logic [1:0]   err_code_q;

  accum_ctrl_t         ctl;
  logic [INSTR_W-1:0]  instr_word, instr_next;
  logic [IMM_W-1:0]    imm_word;
  logic [IC_W-1:0]     instr_cnt;
  logic [MC_W-1:0]     imm_cnt;
  logic                instr_last, imm_last;
  logic [OPC_BITS-1:0] opc;
  logic                accept, handoff, illegal, tmo_abort;

  assign accept  = bus.in_valid & in_ready_q;
  assign handoff = (state == S_HOLD) & bus.out_ready;

  // Decode must see the byte being accepted this cycle, not last cycle's word.
  always_comb begin
    instr_next = instr_word;
    for (int i = 0; i < IB; i++)
      if (instr_cnt == IC_W'(i)) instr_next[i*BYTE_W +: BYTE_W] = bus.in_data;
  end

  assign opc     = instr_next[OPC_W-1:0];
  assign illegal = instr_last & ~is_legal_opc(opc);

  assign ctl.instr_shift = accept & (state == S_INSTR);
  assign ctl.imm_shift   = accept & (state == S_IMM);
  assign ctl.clr         = handoff | illegal | tmo_abort;

  byte_word_accum #(.BYTE_W(BYTE_W), .WORD_W(INSTR_W)) u_instr_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctl.clr),
    .shift_en (ctl.instr_shift),
    .byte_in  (bus.in_data),
    .word_out (instr_word),
    .count    (instr_cnt),
    .last_beat(instr_last)
  );

  byte_word_accum #(.BYTE_W(BYTE_W), .WORD_W(IMM_W)) u_imm_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctl.clr),
    .shift_en (ctl.imm_shift),
    .byte_in  (bus.in_data),
    .word_out (imm_word),
    .count    (imm_cnt),
    .last_beat(imm_last)
  );

`ifdef INSTR_FRAME_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
  logic [TC_W-1:0] tmo_cnt;
  logic            frame_busy;

  assign frame_busy = (state != S_HOLD) && ((instr_cnt != '0) || (imm_cnt != '0));
  // abort on the edge that completes TIMEOUT_CYC idle cycles after the last byte
  assign tmo_abort  = frame_busy && !accept && (tmo_cnt == TC_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || accept || !frame_busy || tmo_abort) tmo_cnt <= '0;
    else                                           tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_sink;
  assign tmo_abort   = 1'b0;
  assign unused_sink = ^{imm_cnt, 32'(TIMEOUT_CYC)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INSTR;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      has_imm_q   <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      case (state)
        S_INSTR: if (instr_last) begin
          if (illegal) begin
            error_q    <= 1'b1;
            err_code_q <= ERR_ILLEGAL_OPC;
          end else if (has_imm(opc)) begin
            state <= S_IMM;
          end else begin
            state       <= S_HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            has_imm_q   <= 1'b0;
          end
        end
        S_IMM: if (imm_last) begin
          state       <= S_HOLD;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b1;
          has_imm_q   <= 1'b1;
        end
        S_HOLD: if (bus.out_ready) begin
          state       <= S_INSTR;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          has_imm_q   <= 1'b0;
        end
        default: state <= S_INSTR;
      endcase
      if (tmo_abort) begin
        state      <= S_INSTR;
        in_ready_q <= 1'b1;
        error_q    <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = instr_word;
  assign bus.out_imm     = has_imm_q ? imm_word : '0;
  assign bus.out_has_imm = has_imm_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: doc/instr_frame_assembler.md
Name: instr_frame_assembler

Overview:
Assembles variable-length instruction frames from a byte-serial fetch stream into a parallel instruction word and an optional immediate. Widths are parametrised. The block applies opcode-dependent frame length, ready/valid backpressure on both sides, and illegal-opcode detection with frame discard. It sits between the serial fetch interface and the decode stage of the serial CPU.

Parameters:
BYTE_W, 8, serial beat width in bits
INSTR_W, 16, instruction word width; must be a multiple of BYTE_W
IMM_W, 16, immediate width; must be a multiple of BYTE_W
OPC_W, 3, opcode field width, taken from instr[OPC_W-1:0]
TIMEOUT_CYC, 64, inter-byte timeout in cycles; used only with the optional feature

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  serial byte present
in_data  input  BYTE_W  serial byte
in_ready  output  1  block accepts a byte this cycle
out_valid  output  1  complete frame held on outputs
out_ready  input  1  decode consumes the frame
out_instr  output  INSTR_W  assembled instruction word
out_imm  output  IMM_W  assembled immediate; 0 when out_has_imm=0
out_has_imm  output  1  frame carried an immediate
error  output  1  one-cycle pulse on frame abort
err_code  output  2  abort cause, valid while error=1: 2'b01 illegal opcode, 2'b10 timeout

Behaviour:
- A byte is accepted when in_valid & in_ready.
- Byte order is little-endian: the first accepted byte lands in bits [BYTE_W-1:0], and each later byte goes to the next higher slice. The immediate uses the same order.
- Beat counts: IB = INSTR_W/BYTE_W, MB = IMM_W/BYTE_W.
- Opcodes come from package opcode_t: R_TYPE=0, I_TYPE=1, B_TYPE=2, J_TYPE=3, M_TYPE=4, SYS_END=7. Values 5 and 6 are illegal.
- Only I_TYPE and M_TYPE carry an immediate.
- FSM states: S_INSTR, S_IMM, S_HOLD.
- S_INSTR: in_ready=1. Accept beats into the instruction accumulator. On acceptance of beat IB, decode the opcode from the completed word, including the byte just accepted:
  - illegal opcode: error=1 and err_code=01 next cycle; discard the frame; stay in S_INSTR with the beat counter cleared;
  - immediate opcode: go to S_IMM;
  - otherwise: go to S_HOLD with out_has_imm=0.
- S_IMM: in_ready=1. Accept MB beats. On the last beat, go to S_HOLD with out_has_imm=1.
- S_HOLD: in_ready=0. out_valid=1. out_instr, out_imm and out_has_imm are stable.
  - When out_ready=1: out_valid drops next cycle, accumulators clear, and the FSM returns to S_INSTR.
  - No byte is accepted in the same cycle as the handoff.
- Latency: out_valid rises exactly one cycle after the final byte of the frame is accepted.
- out_ready while out_valid=0 is ignored.
- in_data is ignored when in_valid=0 or in_ready=0.
- Reset, including mid-frame:
  - all accumulators and counters go to 0;
  - FSM goes to S_INSTR;
  - out_valid=0, out_instr=0, out_imm=0, out_has_imm=0, error=0, err_code=0;
  - in_ready=1 from the first cycle after reset deasserts;
  - a partial frame is lost.
- error is registered and lasts exactly one cycle. err_code returns to 0 after the pulse.

Optional Feature:
Macro: INSTR_FRAME_TIMEOUT_EN.
- Defined:
  - a counter clears on every accepted byte and increments each cycle while a frame is partially received (beat count > 0, in S_INSTR or S_IMM);
  - when the counter reaches TIMEOUT_CYC, the block aborts the frame with error=1 and err_code=10, clears state and returns to S_INSTR;
  - the counter does not run in S_HOLD or with the beat count at 0.
- Not defined: there is no counter, and a partial frame waits indefinitely. err_code=10 is never produced.

Decomposition:
- Shared package cpu_pkg:
  - opcode_t enum;
  - is_legal_opc() and has_imm() functions;
  - err_code localparams ERR_NONE, ERR_ILLEGAL_OPC, ERR_TIMEOUT.
- One sub-module, byte_word_accum (parametrised BYTE_W, WORD_W):
  - ports: clr, shift_en, byte_in, word_out, count, last_beat;
  - it is instantiated twice, once for the instruction and once for the immediate.

Test Plan:
- R_TYPE frame, bytes 0x10, 0x20 on consecutive cycles with out_ready=1 → out_valid high one cycle after 0x20, out_instr=0x2010, out_has_imm=0, out_imm=0.
- I_TYPE frame, bytes 0x01, 0xAB, 0x34, 0x12 → out_instr=0xAB01, out_imm=0x1234, out_has_imm=1. in_ready stays 1 through all four bytes.
- Illegal opcode, bytes 0x05, 0x00 → error pulses one cycle with err_code=01 and out_valid never rises. A following frame 0x02, 0x00 yields out_instr=0x0002.
- Backpressure: complete a J_TYPE frame 0x03, 0x40 with out_ready=0 for 5 cycles → in_ready=0, out_instr held at 0x4003, extra in_valid bytes not consumed. Raise out_ready → out_valid drops next cycle, then in_ready=1.
- Reset mid-frame: accept 0x04, 0x00, 0x11, then assert rst → all outputs reset. A following frame 0x00, 0x00 gives out_instr=0x0000, out_has_imm=0.
- With INSTR_FRAME_TIMEOUT_EN and TIMEOUT_CYC=8: accept 0x01, then idle → error=1 with err_code=10 after 8 idle cycles. The next frame 0x00, 0x01 assembles normally to 0x0100.
